softusb_sie_fifo: RTL and testbench

- Next-generation SoftUSB serial interface engine front end: register-mapped between the navre I/O bus (io_*) and softusb_phy.
- Generalises the single-byte TX/RX holding registers to parametrised-depth TX and RX FIFOs, and generalises port select to NPORTS root ports.
- Adds sticky overflow flags, FIFO level readback and flush control so firmware can move whole packets without per-byte polling.

---
 rtl/softusb_sie_pkg.sv | 39 +++
 rtl/softusb_sie_syncfifo.sv | 52 +++++
 rtl/softusb_sie_fifo.sv | 166 ++++++++++++++++
 tb/tb_softusb_sie_fifo.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softusb_sie_pkg.sv
// SoftUSB SIE front-end register map, CTRL strobe bits and status bit positions.
package softusb_sie_pkg;

  localparam logic [5:0] SIE_LINE_STATE_BASE = 6'h00;
  localparam logic [5:0] SIE_PORT_SEL_RX     = 6'h08;
  localparam logic [5:0] SIE_PORT_SEL_TX     = 6'h09;
  localparam logic [5:0] SIE_TX_DATA         = 6'h0A;
  localparam logic [5:0] SIE_TX_STATUS       = 6'h0B;
  localparam logic [5:0] SIE_RX_DATA         = 6'h0C;
  localparam logic [5:0] SIE_RX_STATUS       = 6'h0D;
  localparam logic [5:0] SIE_RX_LEVEL        = 6'h0E;
  localparam logic [5:0] SIE_GENERATE_RESET  = 6'h0F;
  localparam logic [5:0] SIE_TX_LOW_SPEED    = 6'h10;
  localparam logic [5:0] SIE_LOW_SPEED       = 6'h11;
  localparam logic [5:0] SIE_GEN_EOP         = 6'h12;
  localparam logic [5:0] SIE_CTRL            = 6'h13;
  localparam logic [5:0] SIE_STAT_RX_LO      = 6'h14;
  localparam logic [5:0] SIE_STAT_RX_HI      = 6'h15;
  localparam logic [5:0] SIE_STAT_ERR_LO     = 6'h16;
  localparam logic [5:0] SIE_STAT_ERR_HI     = 6'h17;
  localparam logic [5:0] SIE_STAT_TX_LO      = 6'h18;
  localparam logic [5:0] SIE_STAT_TX_HI      = 6'h19;

  localparam int CTRL_FLUSH_TX  = 0;
  localparam int CTRL_FLUSH_RX  = 1;
  localparam int CTRL_CLR_FLAGS = 2;

  localparam int TXS_BUSY  = 0;
  localparam int TXS_EMPTY = 1;
  localparam int TXS_FULL  = 2;
  localparam int TXS_OVF   = 3;

  localparam int RXS_ACTIVE = 0;
  localparam int RXS_EMPTY  = 1;
  localparam int RXS_FULL   = 2;
  localparam int RXS_OVF    = 3;
  localparam int RXS_ERR    = 4;

endpackage

// File: rtl/softusb_sie_syncfifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop on a full FIFO lets a same-cycle push in.
module softusb_sie_syncfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             usb_clk,
  input  logic             usb_rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [LW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/softusb_sie_fifo.sv
// SoftUSB SIE front end: navre I/O registers, TX/RX FIFOs and root-port control.
// Define SOFTUSB_SIE_STATS_EN to add saturating rx/err/tx byte counters at 0x14-0x19.
module softusb_sie_fifo
  import softusb_sie_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  localparam int TLW = $clog2(TX_DEPTH) + 1,
  localparam int RLW = $clog2(RX_DEPTH) + 1
) (
  input  logic                usb_clk,
  input  logic                usb_rst,
  input  logic                io_re,
  input  logic                io_we,
  input  logic [5:0]          io_a,
  input  logic [7:0]          io_di,
  output logic [7:0]          io_do,
  input  logic [2*NPORTS-1:0] line_state,
  output logic [PW-1:0]       port_sel_rx,
  output logic [NPORTS-1:0]   port_sel_tx,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic                tx_busy,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                rx_active,
  input  logic                rx_error,
  output logic [NPORTS-1:0]   generate_reset,
  output logic                tx_low_speed,
  output logic [NPORTS-1:0]   low_speed,
  output logic                generate_eop
);

  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic [TLW-1:0] tx_level;
  logic [RLW-1:0] rx_level;
  logic [7:0]     rx_head, rd_mux, tx_status, rx_status;
  logic           tx_ovf, rx_ovf, rx_err;

  logic ctrl_we, tx_flush, rx_flush, clr_flags;
  logic tx_push, tx_pop_ok, rx_pop_req, rx_pop_ok, rx_acc;

  assign ctrl_we    = io_we && (io_a == SIE_CTRL);
  assign tx_flush   = ctrl_we && io_di[CTRL_FLUSH_TX];
  assign rx_flush   = ctrl_we && io_di[CTRL_FLUSH_RX];
  assign clr_flags  = ctrl_we && io_di[CTRL_CLR_FLAGS];
  assign tx_push    = io_we && (io_a == SIE_TX_DATA);
  assign tx_pop_ok  = tx_ready && !tx_empty && !tx_flush;
  assign rx_pop_req = io_re && (io_a == SIE_RX_DATA);
  assign rx_pop_ok  = rx_pop_req && !rx_empty && !rx_flush;
  assign rx_acc     = rx_valid && !rx_flush && (!rx_full || rx_pop_ok);
  assign tx_valid   = !tx_empty;

  softusb_sie_syncfifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .usb_clk, .usb_rst,
    .push(tx_push), .pop(tx_ready), .flush(tx_flush), .din(io_di),
    .dout(tx_data), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  softusb_sie_syncfifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .usb_clk, .usb_rst,
    .push(rx_valid), .pop(rx_pop_req), .flush(rx_flush), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_comb begin
    tx_status = '0;
    tx_status[TXS_BUSY]  = tx_busy;
    tx_status[TXS_EMPTY] = tx_empty;
    tx_status[TXS_FULL]  = tx_full;
    tx_status[TXS_OVF]   = tx_ovf;
    rx_status = '0;
    rx_status[RXS_ACTIVE] = rx_active;
    rx_status[RXS_EMPTY]  = rx_empty;
    rx_status[RXS_FULL]   = rx_full;
    rx_status[RXS_OVF]    = rx_ovf;
    rx_status[RXS_ERR]    = rx_err;
  end

`ifdef SOFTUSB_SIE_STATS_EN
  logic [15:0] stat_rx, stat_err, stat_tx;
  logic        stat_clr;

  assign stat_clr = io_we && (io_a == SIE_STAT_RX_LO);

  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      stat_rx  <= '0;
      stat_err <= '0;
      stat_tx  <= '0;
    end else if (stat_clr) begin
      stat_rx  <= '0;
      stat_err <= '0;
      stat_tx  <= '0;
    end else begin
      if (rx_acc && (stat_rx != '1))     stat_rx  <= stat_rx + 16'd1;
      if (rx_error && (stat_err != '1))  stat_err <= stat_err + 16'd1;
      if (tx_pop_ok && (stat_tx != '1))  stat_tx  <= stat_tx + 16'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NPORTS; i++)
      if (io_a == SIE_LINE_STATE_BASE + 6'(i)) rd_mux = {6'b0, line_state[2*i +: 2]};
    case (io_a)
      SIE_PORT_SEL_RX:    rd_mux = 8'(port_sel_rx);
      SIE_PORT_SEL_TX:    rd_mux = 8'(port_sel_tx);
      SIE_TX_DATA:        rd_mux = 8'(tx_level);
      SIE_TX_STATUS:      rd_mux = tx_status;
      // Empty RX reads return 0 rather than the stale slot under the read pointer.
      SIE_RX_DATA:        rd_mux = rx_empty ? 8'h00 : rx_head;
      SIE_RX_STATUS:      rd_mux = rx_status;
      SIE_RX_LEVEL:       rd_mux = 8'(rx_level);
      SIE_GENERATE_RESET: rd_mux = 8'(generate_reset);
      SIE_TX_LOW_SPEED:   rd_mux = {7'b0, tx_low_speed};
      SIE_LOW_SPEED:      rd_mux = 8'(low_speed);
`ifdef SOFTUSB_SIE_STATS_EN
      SIE_STAT_RX_LO:     rd_mux = stat_rx[7:0];
      SIE_STAT_RX_HI:     rd_mux = stat_rx[15:8];
      SIE_STAT_ERR_LO:    rd_mux = stat_err[7:0];
      SIE_STAT_ERR_HI:    rd_mux = stat_err[15:8];
      SIE_STAT_TX_LO:     rd_mux = stat_tx[7:0];
      SIE_STAT_TX_HI:     rd_mux = stat_tx[15:8];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      io_do          <= '0;
      port_sel_rx    <= '0;
      port_sel_tx    <= '0;
      generate_reset <= '0;
      tx_low_speed   <= 1'b0;
      low_speed      <= '0;
      generate_eop   <= 1'b0;
      tx_ovf         <= 1'b0;
      rx_ovf         <= 1'b0;
      rx_err         <= 1'b0;
    end else begin
      io_do        <= rd_mux;
      generate_eop <= io_we && (io_a == SIE_GEN_EOP);
      if (io_we) begin
        case (io_a)
          SIE_PORT_SEL_RX:    port_sel_rx    <= io_di[PW-1:0];
          SIE_PORT_SEL_TX:    port_sel_tx    <= io_di[NPORTS-1:0];
          SIE_GENERATE_RESET: generate_reset <= io_di[NPORTS-1:0];
          SIE_TX_LOW_SPEED:   tx_low_speed   <= io_di[0];
          SIE_LOW_SPEED:      low_speed      <= io_di[NPORTS-1:0];
          default: ;
        endcase
      end
      // A same-cycle set beats the CTRL clear so no event is lost.
      tx_ovf <= (tx_ovf && !clr_flags) || (tx_push && tx_full && !tx_pop_ok && !tx_flush);
      rx_ovf <= (rx_ovf && !clr_flags) || (rx_valid && rx_full && !rx_pop_ok && !rx_flush);
      rx_err <= (rx_err && !clr_flags) || rx_error;
    end
  end

endmodule

// File: tb/tb_softusb_sie_fifo.sv
// Randomized + directed bench for softusb_sie_fifo against a queue-based register model.
module tb_softusb_sie_fifo;

  localparam int NP = 4;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic          usb_clk = 1'b0;
  logic          usb_rst = 1'b1;
  logic          io_re = 1'b0, io_we = 1'b0;
  logic [5:0]    io_a = '0;
  logic [7:0]    io_di = '0;
  logic [7:0]    io_do;
  logic [2*NP-1:0] line_state = '0;
  logic [1:0]    port_sel_rx;
  logic [NP-1:0] port_sel_tx, generate_reset, low_speed;
  logic [7:0]    tx_data, rx_data = '0;
  logic          tx_valid, tx_ready = 1'b0, tx_busy = 1'b0;
  logic          rx_valid = 1'b0, rx_active = 1'b0, rx_error = 1'b0;
  logic          tx_low_speed, generate_eop;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit m_tx_ovf, m_rx_ovf, m_rx_err;

  softusb_sie_fifo #(.NPORTS(NP), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .usb_clk(usb_clk), .usb_rst(usb_rst),
    .io_re(io_re), .io_we(io_we), .io_a(io_a), .io_di(io_di), .io_do(io_do),
    .line_state(line_state), .port_sel_rx(port_sel_rx), .port_sel_tx(port_sel_tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active), .rx_error(rx_error),
    .generate_reset(generate_reset), .tx_low_speed(tx_low_speed),
    .low_speed(low_speed), .generate_eop(generate_eop)
  );

  always #5 usb_clk = ~usb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge usb_clk);
    #1;
  endtask

  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    io_a = a; io_di = d; io_we = 1'b1;
    tick();
    io_we = 1'b0;
  endtask

  task automatic io_read(input logic [5:0] a, output logic [7:0] d);
    io_a = a; io_re = 1'b1;
    tick();
    io_re = 1'b0;
    d = io_do;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (rxq.size() < RXD) rxq.push_back(b); else m_rx_ovf = 1;
  endtask

  task automatic tx_write(input logic [7:0] b);
    io_write(6'h0A, b);
    if (txq.size() < TXD) txq.push_back(b); else m_tx_ovf = 1;
  endtask

  task automatic model_clear;
    txq.delete(); rxq.delete();
    m_tx_ovf = 0; m_rx_ovf = 0; m_rx_err = 0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    usb_rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({io_do, tx_valid, generate_eop} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: io_do=%h tx_valid=%b eop=%b, want 0", io_do, tx_valid, generate_eop);
    end
    vectors++;
    if ({port_sel_rx, port_sel_tx, generate_reset, low_speed, tx_low_speed} !== '0) begin
      miscompares++;
      $display("FAIL reset_masks: sel_rx=%h sel_tx=%h gr=%h ls=%h tls=%b, want 0",
               port_sel_rx, port_sel_tx, generate_reset, low_speed, tx_low_speed);
    end
    usb_rst = 1'b0;
    tick();
    model_clear();
    io_read(6'h0D, d);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL reset_rx_status: got %h want 02", d); end
    io_read(6'h0B, d);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL reset_tx_status: got %h want 02", d); end
  endtask

  task automatic test_tx_basic;
    logic [7:0] d;
    tx_write(8'h80); tx_write(8'h06); tx_write(8'h00);
    io_read(6'h0A, d);
    vectors++;
    if (d !== 8'd3) begin miscompares++; $display("FAIL tx_level_3: got %0d want 3", d); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
        miscompares++;
        $display("FAIL tx_head[%0d]: valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, txq[0]);
      end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      void'(txq.pop_front());
    end
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_valid_drop: got %b want 0", tx_valid); end
    io_read(6'h0A, d);
    vectors++;
    if (d !== 8'd0) begin miscompares++; $display("FAIL tx_level_0: got %0d want 0", d); end
    // tx_ready on an empty FIFO must not disturb anything
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    io_read(6'h0A, d);
    vectors++;
    if (d !== 8'd0) begin miscompares++; $display("FAIL tx_empty_pop: level %0d want 0", d); end
  endtask

  task automatic test_tx_overflow;
    logic [7:0] d, b;
    for (int i = 0; i < TXD + 1; i++) tx_write(8'($urandom));
    io_read(6'h0A, d);
    vectors++;
    if (d !== 8'(txq.size())) begin miscompares++; $display("FAIL tx_full_level: got %0d want %0d", d, txq.size()); end
    io_read(6'h0B, d);
    vectors++;
    if (d !== 8'h0C) begin miscompares++; $display("FAIL tx_ovf_status: got %h want 0C", d); end
    // push and pop together on a full FIFO: both happen, level stays at depth
    b = 8'($urandom);
    io_a = 6'h0A; io_di = b; io_we = 1'b1; tx_ready = 1'b1;
    tick();
    io_we = 1'b0; tx_ready = 1'b0;
    void'(txq.pop_front()); txq.push_back(b);
    vectors++;
    if (tx_data !== txq[0]) begin miscompares++; $display("FAIL tx_full_pushpop_head: got %h want %h", tx_data, txq[0]); end
    io_read(6'h0A, d);
    vectors++;
    if (d !== 8'd16) begin miscompares++; $display("FAIL tx_full_pushpop_level: got %0d want 16", d); end
    io_write(6'h13, 8'h05);
    txq.delete(); m_tx_ovf = 0;
    io_read(6'h0A, d);
    vectors++;
    if (d !== 8'd0) begin miscompares++; $display("FAIL tx_flush_level: got %0d want 0", d); end
    io_read(6'h0B, d);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL tx_flush_status: got %h want 02", d); end
  endtask

  task automatic test_rx_basic;
    logic [7:0] d;
    rx_push(8'hC3);
    rx_error = 1'b1; tick(); rx_error = 1'b0; m_rx_err = 1;
    rx_push(8'h4B);
    io_read(6'h0E, d);
    vectors++;
    if (d !== 8'd2) begin miscompares++; $display("FAIL rx_level_2: got %0d want 2", d); end
    for (int i = 0; i < 2; i++) begin
      io_read(6'h0C, d);
      vectors++;
      if (d !== rxq[0]) begin miscompares++; $display("FAIL rx_data[%0d]: got %h want %h", i, d, rxq[0]); end
      void'(rxq.pop_front());
    end
    io_read(6'h0D, d);
    vectors++;
    if (d !== 8'h12) begin miscompares++; $display("FAIL rx_err_status: got %h want 12", d); end
    io_read(6'h0C, d);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL rx_empty_read: got %h want 00", d); end
    io_read(6'h0E, d);
    vectors++;
    if (d !== 8'd0) begin miscompares++; $display("FAIL rx_empty_level: got %0d want 0", d); end
    io_write(6'h13, 8'h04); m_rx_err = 0;
    io_read(6'h0D, d);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL rx_clear_status: got %h want 02", d); end
  endtask

  task automatic test_rx_full_pop;
    logic [7:0] d, b;
    for (int i = 0; i < RXD; i++) rx_push(8'($urandom));
    b = 8'($urandom);
    rx_data = b; rx_valid = 1'b1; io_a = 6'h0C; io_re = 1'b1;
    tick();
    rx_valid = 1'b0; io_re = 1'b0;
    vectors++;
    if (io_do !== rxq[0]) begin miscompares++; $display("FAIL rx_full_pop_data: got %h want %h", io_do, rxq[0]); end
    void'(rxq.pop_front()); rxq.push_back(b);
    io_read(6'h0E, d);
    vectors++;
    if (d !== 8'd16) begin miscompares++; $display("FAIL rx_full_pop_level: got %0d want 16", d); end
    io_read(6'h0D, d);
    vectors++;
    if (d !== 8'h04) begin miscompares++; $display("FAIL rx_full_no_ovf: got %h want 04", d); end
    rx_push(8'hEE);
    io_read(6'h0D, d);
    vectors++;
    if (d !== 8'h0C) begin miscompares++; $display("FAIL rx_ovf_status: got %h want 0C", d); end
    while (rxq.size() > 0) begin
      io_read(6'h0C, d);
      vectors++;
      if (d !== rxq[0]) begin miscompares++; $display("FAIL rx_drain: got %h want %h", d, rxq[0]); end
      void'(rxq.pop_front());
    end
    io_write(6'h13, 8'h07);
    model_clear();
    io_read(6'h0D, d);
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL rx_drain_status: got %h want 02", d); end
  endtask

  task automatic test_ports_eop;
    logic [7:0] d, v;
    logic [7:0] ls;
    ls = 8'b10_01_00_11;
    line_state = ls;
    for (int i = 0; i < NP; i++) begin
      io_read(6'(i), d);
      vectors++;
      if (d !== {6'b0, ls[2*i +: 2]}) begin miscompares++; $display("FAIL line_state[%0d]: got %h want %h", i, d, ls[2*i +: 2]); end
    end
    io_read(6'h04, d);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL unmapped_read: got %h want 00", d); end
    v = 8'($urandom);
    io_write(6'h09, v); io_write(6'h0F, ~v); io_write(6'h11, v ^ 8'h5A);
    io_write(6'h08, v); io_write(6'h10, 8'h01);
    vectors++;
    if ({port_sel_tx, generate_reset, low_speed, port_sel_rx, tx_low_speed} !==
        {v[3:0], ~v[3:0], v[3:0] ^ 4'hA, v[1:0], 1'b1}) begin
      miscompares++;
      $display("FAIL port_masks: sel_tx=%h gr=%h ls=%h sel_rx=%h tls=%b v=%h",
               port_sel_tx, generate_reset, low_speed, port_sel_rx, tx_low_speed, v);
    end
    io_read(6'h09, d);
    vectors++;
    if (d !== {4'b0, v[3:0]}) begin miscompares++; $display("FAIL port_sel_tx_read: got %h want %h", d, v[3:0]); end
    vectors++;
    if (generate_eop !== 1'b0) begin miscompares++; $display("FAIL eop_idle: got %b want 0", generate_eop); end
    io_write(6'h12, 8'h00);
    vectors++;
    if (generate_eop !== 1'b1) begin miscompares++; $display("FAIL eop_pulse: got %b want 1", generate_eop); end
    tick();
    vectors++;
    if (generate_eop !== 1'b0) begin miscompares++; $display("FAIL eop_one_cycle: got %b want 0", generate_eop); end
  endtask

  task automatic test_stats;
    logic [7:0] d;
`ifdef SOFTUSB_SIE_STATS_EN
    logic [7:0] exp_s [6];
    io_write(6'h14, 8'h00);
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    rx_error = 1'b1; tick(); rx_error = 1'b0;
    tx_write(8'hA1); tx_write(8'hA2);
    tx_ready = 1'b1; tick(); tick(); tick(); tx_ready = 1'b0;
    exp_s = '{8'd3, 8'd0, 8'd1, 8'd0, 8'd2, 8'd0};
    for (int i = 0; i < 6; i++) begin
      io_read(6'h14 + 6'(i), d);
      vectors++;
      if (d !== exp_s[i]) begin miscompares++; $display("FAIL stat[%0d]: got %0d want %0d", i, d, exp_s[i]); end
    end
    io_write(6'h13, 8'h07);
    model_clear();
`else
    io_write(6'h14, 8'hFF);
    rx_push(8'h11);
    for (int i = 0; i < 6; i++) begin
      io_read(6'h14 + 6'(i), d);
      vectors++;
      if (d !== 8'h00) begin miscompares++; $display("FAIL stat_absent[%0d]: got %h want 00", i, d); end
    end
    io_write(6'h13, 8'h07);
    model_clear();
`endif
  endtask

  task automatic test_random;
    logic [7:0] exp_do, b;
    bit have_exp, pop_ok;
    int op;
    have_exp = 0;
    exp_do = '0;
    for (int n = 0; n < 400; n++) begin
      vectors++;
      if (tx_valid !== (txq.size() != 0)) begin miscompares++; $display("FAIL rnd_tx_valid[%0d]: got %b want %b", n, tx_valid, txq.size() != 0); end
      if (txq.size() != 0) begin
        vectors++;
        if (tx_data !== txq[0]) begin miscompares++; $display("FAIL rnd_tx_data[%0d]: got %h want %h", n, tx_data, txq[0]); end
      end
      if (have_exp) begin
        vectors++;
        if (io_do !== exp_do) begin miscompares++; $display("FAIL rnd_io_do[%0d]: got %h want %h", n, io_do, exp_do); end
      end
      op = $urandom_range(0, 5);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = $urandom_range(0, 1);
      rx_data = 8'($urandom);
      rx_error = ($urandom_range(0, 15) == 0);
      tx_busy = $urandom_range(0, 1);
      rx_active = $urandom_range(0, 1);
      b = 8'($urandom);
      io_we = (op == 0); io_re = (op != 0); io_di = b;
      case (op)
        0: io_a = 6'h0A;
        1: io_a = 6'h0C;
        2: io_a = 6'h0A;
        3: io_a = 6'h0E;
        4: io_a = 6'h0B;
        default: io_a = 6'h0D;
      endcase
      // expected read data comes from the state before this edge
      case (op)
        0, 2: exp_do = 8'(txq.size());
        1: exp_do = (rxq.size() != 0) ? rxq[0] : 8'h00;
        3: exp_do = 8'(rxq.size());
        4: exp_do = {4'b0, m_tx_ovf, txq.size() == TXD, txq.size() == 0, tx_busy};
        default: exp_do = {3'b0, m_rx_err, m_rx_ovf, rxq.size() == RXD, rxq.size() == 0, rx_active};
      endcase
      have_exp = 1;
      if (tx_ready && txq.size() != 0) void'(txq.pop_front());
      if (op == 0) begin
        if (txq.size() < TXD) txq.push_back(b); else m_tx_ovf = 1;
      end
      pop_ok = (op == 1) && (rxq.size() != 0);
      if (pop_ok) void'(rxq.pop_front());
      if (rx_valid) begin
        if (rxq.size() < RXD) rxq.push_back(rx_data); else m_rx_ovf = 1;
      end
      if (rx_error) m_rx_err = 1;
      tick();
    end
    io_we = 0; io_re = 0; tx_ready = 0; rx_valid = 0; rx_error = 0; tx_busy = 0; rx_active = 0;
    vectors++;
    if (io_do !== exp_do) begin miscompares++; $display("FAIL rnd_io_do_last: got %h want %h", io_do, exp_do); end
    io_write(6'h13, 8'h07);
    model_clear();
  endtask

  task automatic test_reset_midpacket;
    logic [7:0] d;
    tx_write(8'h2D); tx_write(8'h00); tx_write(8'h10);
    rx_push(8'h99);
    #2;
    usb_rst = 1'b1;
    #1;
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_tx_valid: got %b want 0", tx_valid); end
    vectors++;
    if ({io_do, port_sel_tx, generate_reset, low_speed} !== '0) begin
      miscompares++;
      $display("FAIL midreset_regs: io_do=%h sel_tx=%h gr=%h ls=%h, want 0", io_do, port_sel_tx, generate_reset, low_speed);
    end
    tick();
    usb_rst = 1'b0;
    model_clear();
    tick();
    io_read(6'h0E, d);
    vectors++;
    if (d !== 8'd0) begin miscompares++; $display("FAIL midreset_rx_level: got %0d want 0", d); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_basic();
    test_rx_full_pop();
    test_ports_eop();
    test_stats();
    test_random();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
